mux_rr_arbiter: RTL

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes on every input and on the output. It selects either a software-chosen channel (manual mode) or the next requesting channel in round-robin order, and registers the winner's data in a one-entry output stage. It is the successor to the combinational 4:1 selector. It sits wherever several producers share one downstream consumer.

---
 rtl/mux_rr_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mux_rr_arbiter.sv
// N-channel registered multiplexer with valid/ready on every port.
// Winner is either the software-selected channel or the next requester in round-robin order.
module mux_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_ch,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int SEL_SPAN = 1 << SEL_W;

    logic [WIDTH-1:0]      out_data_r;
    logic [SEL_W-1:0]      out_ch_r;
    logic                  out_valid_r;
    logic [SEL_W-1:0]      ptr_r;

    logic                  load_en_s;
    logic                  grant_s;
    logic                  xfer_s;
    logic [SEL_W-1:0]      winner_s;
    logic [SEL_W-1:0]      ptr_next_s;
    logic [WIDTH-1:0]      win_data_s;
    logic [CHANNELS-1:0]   in_ready_s;

    logic [2*CHANNELS-1:0] rot_dbl_s;
    logic [CHANNELS-1:0]   rot_s;
    logic                  rr_found_s;
    logic [SEL_W-1:0]      rr_off_s;
    logic [SEL_W:0]        rr_sum_s;
    logic [SEL_W-1:0]      rr_idx_s;

    logic [SEL_SPAN-1:0]   valid_span_s;
    logic                  man_ok_s;
    logic                  man_grant_s;

    // No channel is accepted while reset is held, even though the output stage is empty.
    assign load_en_s = rst_n && (!out_valid_r || out_ready);

    // Rotating the request vector by ptr turns the wrap-around search into a plain priority pick.
    assign rot_dbl_s = {in_valid, in_valid} >> ptr_r;
    assign rot_s     = rot_dbl_s[CHANNELS-1:0];

    // Zero-padded copy lets an out-of-range sel index safely and read 0.
    assign valid_span_s = SEL_SPAN'(in_valid);
    assign man_ok_s     = ({1'b0, sel} < (SEL_W+1)'(CHANNELS));
    assign man_grant_s  = man_ok_s && valid_span_s[sel];

    // Lowest rotated offset with a request wins.
    always_comb begin
        rr_found_s = 1'b0;
        rr_off_s   = {SEL_W{1'b0}};
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                rr_found_s = 1'b1;
                rr_off_s   = SEL_W'(k);
            end else begin
                rr_found_s = rr_found_s;
            end
        end
    end

    // Map the rotated offset back to an absolute channel index modulo CHANNELS.
    always_comb begin
        rr_sum_s = {1'b0, ptr_r} + {1'b0, rr_off_s};
        if (rr_sum_s >= (SEL_W+1)'(CHANNELS)) begin
            rr_idx_s = SEL_W'(rr_sum_s - (SEL_W+1)'(CHANNELS));
        end else begin
            rr_idx_s = rr_sum_s[SEL_W-1:0];
        end
    end

    // Choose between manual and round-robin arbitration.
    always_comb begin
        grant_s  = 1'b0;
        winner_s = {SEL_W{1'b0}};
        if (mode) begin
            grant_s  = rr_found_s;
            winner_s = rr_idx_s;
        end else begin
            grant_s  = man_grant_s;
            winner_s = sel;
        end
    end

    // Winner data mux and one-hot accept vector.
    always_comb begin
        win_data_s = {WIDTH{1'b0}};
        in_ready_s = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            if (winner_s == SEL_W'(i)) begin
                win_data_s    = in_data[i*WIDTH +: WIDTH];
                in_ready_s[i] = load_en_s && grant_s;
            end else begin
                in_ready_s[i] = 1'b0;
            end
        end
    end

    assign xfer_s     = load_en_s && grant_s;
    assign ptr_next_s = (winner_s == SEL_W'(CHANNELS - 1)) ? {SEL_W{1'b0}} : (winner_s + SEL_W'(1));

    // Output stage and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r  <= {WIDTH{1'b0}};
            out_ch_r    <= {SEL_W{1'b0}};
            out_valid_r <= 1'b0;
            ptr_r       <= {SEL_W{1'b0}};
        end else if (xfer_s) begin
            out_data_r  <= win_data_s;
            out_ch_r    <= winner_s;
            out_valid_r <= 1'b1;
            ptr_r       <= mode ? ptr_next_s : ptr_r;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_data  = out_data_r;
    assign out_ch    = out_ch_r;
    assign out_valid = out_valid_r;

endmodule
